// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// baud divider computation, reusable by a future transmitter.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Rounded clocks per oversample tick.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, decoded byte and status strobes out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] command;
    logic       rx_valid;
    logic       frame_err;

    modport master (output rx, input command, input rx_valid, input frame_err);
    modport slave  (input rx, output command, output rx_valid, output frame_err);
endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// Oversample tick divider: one tick every DIV clocks, restartable by clear
// so the sampling phase can be aligned to a start edge.
module baud_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = !clear && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver with 3-sample majority voting per bit,
// a one-clock valid strobe per good byte and a framing error strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input logic   clk,
    input logic   rst_n,
    uart_rx_if.slave bus
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    uart_state_t state;
    logic          rx_m, rx_s, rx_prev;
    logic          tick, start_edge, decide, wrap, bit_val;
    logic          s0, s1, bit_done;
    logic [TW-1:0] tcnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg, command_r;
    logic          rx_valid_r, frame_err_r;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = (state == IDLE) && rx_prev && !rx_s;
    assign decide     = tick && (tcnt == MID + TW'(1));
    assign wrap       = tick && (tcnt == LAST);
    assign bit_val    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_edge),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            s0   <= 1'b1;
            s1   <= 1'b1;
        end else if (start_edge) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= (tcnt == LAST) ? '0 : tcnt + TW'(1);
            if (tcnt == MID - TW'(1)) s0 <= rx_s;
            if (tcnt == MID)          s1 <= rx_s;
        end
    end

    // The START->DATA move happens mid start bit, so the first wrap seen in
    // DATA closes the start bit; bit_done marks that a data bit was decided.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_idx     <= '0;
            bit_done    <= 1'b0;
            shreg       <= '0;
            command_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) state <= START;
                end
                START: begin
                    if (decide) begin
                        state    <= bit_val ? IDLE : DATA;
                        bit_idx  <= '0;
                        bit_done <= 1'b0;
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg    <= {bit_val, shreg[7:1]};
                        bit_done <= 1'b1;
                    end else if (wrap && bit_done) begin
                        bit_done <= 1'b0;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (decide) begin
                        state <= IDLE;
                        if (bit_val) begin
                            command_r  <= shreg;
                            rx_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.command   = command_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
endmodule
